int_vec_ctrl8: RTL

- Eight-source interrupt controller that drives the 3-bit select of the 8:1 32-bit vector/handler-address multiplexer in the interrupt path.
- Latches requests, applies a software mask and picks the highest-priority eligible source (index 0 highest).
- Holds the select stable through a req/ack handshake with the CPU, and tracks one in-service source until the CPU returns via eret.
- Single-level only: no nesting.

---
 rtl/int_vec_ctrl8.sv | 107 ++++++++++
 1 files changed

// File: rtl/int_vec_ctrl8.sv
// Eight-source interrupt controller. It latches requests, masks them, and picks the lowest eligible index.
// It then holds the vector-mux select through a req/ack/eret handshake, with a single service level.
module int_vec_ctrl8 #(
  parameter bit         EDGE_MODE = 1'b1,
  parameter logic [7:0] MASK_RST  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       ack,
  input  logic       eret,
  output logic       int_req,
  output logic [2:0] vec_sel,
  output logic [7:0] pending,
  output logic [7:0] in_service,
  output logic [7:0] mask
);

  // state   | meaning
  // IDLE    | nothing raised; arbitrating eligible pending sources
  // REQ     | int_req high, vec_sel frozen, waiting for ack
  // SERVICE | source in service, waiting for eret
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t     state, state_nxt;
  logic [7:0] irq_d;
  logic [7:0] eligible;
  logic [7:0] pend_nxt;
  logic [7:0] clr;
  logic [7:0] insvc_nxt;
  logic [2:0] winner;
  logic [2:0] vec_nxt;
  logic       int_req_nxt;

  assign eligible = pending & ~mask & ~in_service;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    int_req_nxt = int_req;
    vec_nxt     = vec_sel;
    insvc_nxt   = in_service;
    clr         = 8'h00;
    case (state)
      S_IDLE: begin
        int_req_nxt = 1'b0;
        if (|eligible) begin
          vec_nxt     = winner;
          int_req_nxt = 1'b1;
          state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          int_req_nxt = 1'b0;
          insvc_nxt   = 8'h01 << vec_sel;
          clr         = 8'h01 << vec_sel;
          state_nxt   = S_SERVICE;
        end
      end
      S_SERVICE: begin
        int_req_nxt = 1'b0;
        if (eret) begin
          insvc_nxt = 8'h00;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new edge wins over an ack clear of the same bit.
  always_comb begin
    if (EDGE_MODE) pend_nxt = (pending & ~clr) | (irq & ~irq_d);
    else           pend_nxt = irq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      int_req    <= 1'b0;
      vec_sel    <= 3'd0;
      pending    <= 8'h00;
      in_service <= 8'h00;
      mask       <= MASK_RST;
      irq_d      <= 8'hFF;
    end else begin
      state      <= state_nxt;
      int_req    <= int_req_nxt;
      vec_sel    <= vec_nxt;
      pending    <= pend_nxt;
      in_service <= insvc_nxt;
      irq_d      <= irq;
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule
